// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Hazard and sequencing controller for a 5-stage MIPS pipeline.
//            Generates PC/IF-ID stalls, ID/EX bubbles, IF/ID flushes and the
//            MEM->ID forwarding selects used by the ID-stage branch/jr
//            resolver. Interrupts are accepted only outside stalls and
//            control transfers, then masked until kernel mode is reached
//            or a timeout expires.
// Ports    : clk, reset (async, active-high)
//            ID_*  : ID-stage instruction fields and decode flags
//            EX_*  : EX-stage register-write / load controls and destination
//            MEM_* : MEM-stage register-write / load controls and destination
//            IRQ   : level-sensitive external interrupt request
//            PC_Stall, IFID_Stall, IDEX_Flush, IFID_Flush,
//            ForwardC, ForwardD, IRQ_Take : combinational control outputs
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int IRQ_MASK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_UseRt,
  input  logic       ID_Branch,
  input  logic       ID_JumpReg,
  input  logic       ID_Jump,
  input  logic       ID_Taken,
  input  logic       ID_Valid,
  input  logic       ID_PC31,
  input  logic       IRQ,
  input  logic       EX_RegWr,
  input  logic       EX_MemRd,
  input  logic [4:0] EX_WrReg,
  input  logic       MEM_RegWr,
  input  logic       MEM_MemRd,
  input  logic [4:0] MEM_WrReg,
  output logic       PC_Stall,
  output logic       IFID_Stall,
  output logic       IDEX_Flush,
  output logic       IFID_Flush,
  output logic       ForwardC,
  output logic       ForwardD,
  output logic       IRQ_Take
);

  localparam int c_TW = (IRQ_MASK_CYCLES > 1) ? $clog2(IRQ_MASK_CYCLES) : 1;
  localparam logic [c_TW-1:0] c_TIMER_LOAD = c_TW'(IRQ_MASK_CYCLES - 1);

  localparam logic [1:0] c_RUN      = 2'd0;
  localparam logic [1:0] c_STALL    = 2'd1;
  localparam logic [1:0] c_IRQ_MASK = 2'd2;

  logic [1:0]      r_state, w_state_nxt;
  logic [1:0]      r_cnt, w_cnt_nxt;
  logic [c_TW-1:0] r_timer, w_timer_nxt;
  // Remembers that a 2-cycle stall interrupted the IRQ mask window, so the
  // window resumes (with the timer still running) once the stall drains.
  logic            r_mask_ret, w_mask_ret_nxt;

  logic       w_hit_ex_s, w_hit_ex_t, w_hit_mem_s, w_hit_mem_t;
  logic       w_ex_hit, w_mem_hit, w_need_id;
  logic       w_req1, w_req2;
  logic [1:0] w_req_n;
  logic       w_stalling, w_irq_ok;
  logic       w_mask_active, w_mask_cont;

  // Dependency detection; register $0 never creates a hazard.
  assign w_hit_ex_s  = EX_RegWr & (EX_WrReg != 5'd0) & (EX_WrReg == ID_rs);
  assign w_hit_ex_t  = EX_RegWr & (EX_WrReg != 5'd0) & (EX_WrReg == ID_rt) & ID_UseRt;
  assign w_hit_mem_s = MEM_RegWr & (MEM_WrReg != 5'd0) & (MEM_WrReg == ID_rs);
  assign w_hit_mem_t = MEM_RegWr & (MEM_WrReg != 5'd0) & (MEM_WrReg == ID_rt) & ID_UseRt;
  assign w_ex_hit    = w_hit_ex_s | w_hit_ex_t;
  assign w_mem_hit   = w_hit_mem_s | w_hit_mem_t;
  assign w_need_id   = ID_Valid & (ID_Branch | ID_JumpReg);

  // Stall length request: the longest applicable hazard wins.
  assign w_req2  = w_need_id & EX_MemRd & w_ex_hit;
  assign w_req1  = (EX_MemRd & w_ex_hit) | (w_need_id & w_ex_hit) |
                   (w_need_id & MEM_MemRd & w_mem_hit);
  assign w_req_n = w_req2 ? 2'd2 : (w_req1 ? 2'd1 : 2'd0);

  assign w_stalling = (r_state == c_STALL) | (w_req_n != 2'd0);
  assign w_irq_ok   = (r_state == c_RUN) & IRQ & ~ID_PC31 & ID_Valid &
                      (w_req_n == 2'd0) & ~ID_Branch & ~ID_Jump & ~ID_JumpReg;

  // Mask timer runs in IRQ_MASK and through any stall taken from it.
  assign w_mask_active = (r_state == c_IRQ_MASK) | ((r_state == c_STALL) & r_mask_ret);
  assign w_mask_cont   = w_mask_active & ~ID_PC31 & (r_timer != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_RUN;
      r_cnt      <= 2'd0;
      r_timer    <= '0;
      r_mask_ret <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_timer    <= w_timer_nxt;
      r_mask_ret <= w_mask_ret_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_timer_nxt    = w_mask_cont ? (r_timer - c_TW'(1)) : '0;
    w_mask_ret_nxt = r_mask_ret;
    case (r_state)
      c_RUN: begin
        if (w_req_n == 2'd2) begin
          w_state_nxt    = c_STALL;
          w_cnt_nxt      = 2'd1;
          w_mask_ret_nxt = 1'b0;
        end else if (w_irq_ok) begin
          w_state_nxt = c_IRQ_MASK;
          w_timer_nxt = c_TIMER_LOAD;
        end
      end
      c_IRQ_MASK: begin
        if (w_req_n == 2'd2) begin
          w_state_nxt    = c_STALL;
          w_cnt_nxt      = 2'd1;
          w_mask_ret_nxt = w_mask_cont;
        end else if (!w_mask_cont) begin
          w_state_nxt = c_RUN;
        end
      end
      c_STALL: begin
        w_mask_ret_nxt = r_mask_ret & w_mask_cont;
        if (r_cnt <= 2'd1) begin
          w_cnt_nxt   = 2'd0;
          w_state_nxt = (r_mask_ret & w_mask_cont) ? c_IRQ_MASK : c_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      default: begin
        w_state_nxt    = c_RUN;
        w_cnt_nxt      = 2'd0;
        w_mask_ret_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    PC_Stall   = w_stalling;
    IFID_Stall = w_stalling;
    IDEX_Flush = w_stalling;
    // Stall wins over flush; the branch is re-resolved once operands are ready.
    IFID_Flush = ID_Valid & ~w_stalling & ((ID_Branch & ID_Taken) | ID_Jump);
    ForwardC   = w_need_id & w_hit_mem_s & ~MEM_MemRd;
    ForwardD   = w_need_id & w_hit_mem_t & ~MEM_MemRd;
    IRQ_Take   = w_irq_ok;
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Self-checking bench for pipeline_hazard_ctrl: directed hazard,
//            flush, forwarding, IRQ-mask and reset scenarios followed by
//            randomized traffic against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int c_MASK = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_rs, ID_rt, EX_WrReg, MEM_WrReg;
  logic       ID_UseRt, ID_Branch, ID_JumpReg, ID_Jump, ID_Taken, ID_Valid, ID_PC31, IRQ;
  logic       EX_RegWr, EX_MemRd, MEM_RegWr, MEM_MemRd;
  logic       PC_Stall, IFID_Stall, IDEX_Flush, IFID_Flush, ForwardC, ForwardD, IRQ_Take;

  int tests = 0;
  int fails = 0;

  // Reference model state: extra forced stall cycles and IRQ mask window.
  int m_stall_left = 0;
  bit m_mask       = 0;
  int m_mask_left  = 0;

  // Outputs captured at the last sample point.
  logic s_stall, s_iflush, s_fc, s_fd, s_take;

  pipeline_hazard_ctrl #(.IRQ_MASK_CYCLES(c_MASK)) dut (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRt(ID_UseRt), .ID_Branch(ID_Branch),
    .ID_JumpReg(ID_JumpReg), .ID_Jump(ID_Jump), .ID_Taken(ID_Taken),
    .ID_Valid(ID_Valid), .ID_PC31(ID_PC31), .IRQ(IRQ),
    .EX_RegWr(EX_RegWr), .EX_MemRd(EX_MemRd), .EX_WrReg(EX_WrReg),
    .MEM_RegWr(MEM_RegWr), .MEM_MemRd(MEM_MemRd), .MEM_WrReg(MEM_WrReg),
    .PC_Stall(PC_Stall), .IFID_Stall(IFID_Stall), .IDEX_Flush(IDEX_Flush),
    .IFID_Flush(IFID_Flush), .ForwardC(ForwardC), .ForwardD(ForwardD),
    .IRQ_Take(IRQ_Take)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ID_rs = 0; ID_rt = 0; ID_UseRt = 0; ID_Branch = 0; ID_JumpReg = 0;
    ID_Jump = 0; ID_Taken = 0; ID_Valid = 0; ID_PC31 = 0; IRQ = 0;
    EX_RegWr = 0; EX_MemRd = 0; EX_WrReg = 0;
    MEM_RegWr = 0; MEM_MemRd = 0; MEM_WrReg = 0;
  endtask

  task automatic model_reset();
    m_stall_left = 0; m_mask = 0; m_mask_left = 0;
  endtask

  // Stall cycles demanded by the current ID instruction's dependencies.
  function automatic int model_req();
    bit ex_hit, mem_hit, need;
    int n;
    ex_hit  = EX_RegWr && EX_WrReg != 0 &&
              (EX_WrReg == ID_rs || (ID_UseRt && EX_WrReg == ID_rt));
    mem_hit = MEM_RegWr && MEM_WrReg != 0 &&
              (MEM_WrReg == ID_rs || (ID_UseRt && MEM_WrReg == ID_rt));
    need    = ID_Valid && (ID_Branch || ID_JumpReg);
    n = 0;
    if (EX_MemRd && ex_hit) n = 1;
    if (need && ex_hit) n = EX_MemRd ? 2 : ((n > 1) ? n : 1);
    if (need && MEM_MemRd && mem_hit && n < 1) n = 1;
    return n;
  endfunction

  // One clock: inputs are already applied; sample at the falling edge,
  // compare every output with the model, then advance the model at the
  // rising edge and return just after it.
  task automatic do_cycle();
    int  n;
    bit  need, stall, take, fc, fd, fl;
    @(negedge clk);
    n     = model_req();
    need  = ID_Valid && (ID_Branch || ID_JumpReg);
    stall = (m_stall_left > 0) || (n > 0);
    take  = !m_mask && m_stall_left == 0 && IRQ && !ID_PC31 && ID_Valid &&
            n == 0 && !ID_Branch && !ID_Jump && !ID_JumpReg;
    fc    = need && MEM_RegWr && !MEM_MemRd && MEM_WrReg != 0 && MEM_WrReg == ID_rs;
    fd    = need && MEM_RegWr && !MEM_MemRd && MEM_WrReg != 0 && ID_UseRt && MEM_WrReg == ID_rt;
    fl    = ID_Valid && !stall && ((ID_Branch && ID_Taken) || ID_Jump);
    s_stall = PC_Stall; s_iflush = IFID_Flush; s_fc = ForwardC; s_fd = ForwardD; s_take = IRQ_Take;
    check("pc_stall",   PC_Stall,   stall);
    check("ifid_stall", IFID_Stall, stall);
    check("idex_flush", IDEX_Flush, stall);
    check("ifid_flush", IFID_Flush, fl);
    check("forward_c",  ForwardC,   fc);
    check("forward_d",  ForwardD,   fd);
    check("irq_take",   IRQ_Take,   take);
    @(posedge clk);
    if (m_mask) begin
      if (ID_PC31 || m_mask_left == 0) m_mask = 0;
      else m_mask_left--;
    end
    if (take) begin
      m_mask = 1; m_mask_left = c_MASK - 1;
    end
    if (m_stall_left > 0) m_stall_left--;
    else if (n == 2) m_stall_left = 1;
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    model_reset();
    #12;
    check("reset_pc_stall", PC_Stall, 1'b0);
    check("reset_irq_take", IRQ_Take, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Load-use: lw $2 in EX, add $3,$2,$4 in ID.
    EX_RegWr = 1; EX_MemRd = 1; EX_WrReg = 2;
    ID_Valid = 1; ID_rs = 2; ID_rt = 4; ID_UseRt = 1;
    do_cycle(); check("lu_stall1", s_stall, 1'b1); check("lu_noflush", s_iflush, 1'b0);
    EX_RegWr = 0; EX_MemRd = 0; EX_WrReg = 0;
    MEM_RegWr = 1; MEM_MemRd = 1; MEM_WrReg = 2;
    do_cycle(); check("lu_stall_end", s_stall, 1'b0);

    // lw $5 in EX, beq $5,$6 taken: two stalls then a flush.
    clear_inputs();
    EX_RegWr = 1; EX_MemRd = 1; EX_WrReg = 5;
    ID_Valid = 1; ID_rs = 5; ID_rt = 6; ID_UseRt = 1; ID_Branch = 1; ID_Taken = 1;
    do_cycle(); check("lb_stall1", s_stall, 1'b1); check("lb_fc1", s_fc, 1'b0);
    EX_RegWr = 0; EX_MemRd = 0; EX_WrReg = 0;
    MEM_RegWr = 1; MEM_MemRd = 1; MEM_WrReg = 5;
    do_cycle(); check("lb_stall2", s_stall, 1'b1); check("lb_fc2", s_fc, 1'b0);
    MEM_RegWr = 0; MEM_MemRd = 0; MEM_WrReg = 0;
    do_cycle(); check("lb_stall3", s_stall, 1'b0); check("lb_flush", s_iflush, 1'b1);

    // add $7 in EX, bne $7,$0: one stall, then ForwardC from MEM.
    clear_inputs();
    EX_RegWr = 1; EX_WrReg = 7;
    ID_Valid = 1; ID_rs = 7; ID_rt = 0; ID_UseRt = 1; ID_Branch = 1; ID_Taken = 1;
    do_cycle(); check("ab_stall", s_stall, 1'b1);
    EX_RegWr = 0; EX_WrReg = 0;
    MEM_RegWr = 1; MEM_WrReg = 7;
    do_cycle();
    check("ab_fc", s_fc, 1'b1); check("ab_fd", s_fd, 1'b0); check("ab_flush", s_iflush, 1'b1);

    // Zero register never creates a hazard.
    clear_inputs();
    EX_RegWr = 1; EX_MemRd = 1; EX_WrReg = 0; ID_Valid = 1; ID_rs = 0;
    do_cycle(); check("zero_nostall", s_stall, 1'b0);

    // IRQ mask window: taken, masked 8 cycles, re-taken on cycle 9.
    clear_inputs();
    IRQ = 1; ID_Valid = 1; ID_rs = 1; ID_rt = 2; ID_UseRt = 1;
    do_cycle(); check("irq_take0", s_take, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      do_cycle();
      check($sformatf("irq_cyc%0d", c), s_take, (c == 9));
    end
    // Kernel-mode bit seen on mask cycle 3 ends the window early.
    for (int c = 1; c <= 4; c++) begin
      ID_PC31 = (c == 3);
      do_cycle();
      check($sformatf("irq_pc31_cyc%0d", c), s_take, (c == 4));
    end
    IRQ = 0; ID_PC31 = 0;
    repeat (9) do_cycle();

    // Reset during the second cycle of a 2-cycle stall.
    clear_inputs();
    EX_RegWr = 1; EX_MemRd = 1; EX_WrReg = 9;
    ID_Valid = 1; ID_rs = 9; ID_JumpReg = 1; ID_Jump = 1;
    do_cycle(); check("rs_stall1", s_stall, 1'b1);
    EX_RegWr = 0; EX_MemRd = 0; EX_WrReg = 0;
    #1; check("rs_stall2", PC_Stall, 1'b1);
    reset = 1'b1; clear_inputs();
    #1;
    check("rs_pc_stall",   PC_Stall,   1'b0);
    check("rs_ifid_stall", IFID_Stall, 1'b0);
    check("rs_idex_flush", IDEX_Flush, 1'b0);
    check("rs_ifid_flush", IFID_Flush, 1'b0);
    model_reset();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    ID_Valid = 1; ID_rs = 3; ID_rt = 4; ID_UseRt = 1;
    do_cycle(); check("rs_no_residual", s_stall, 1'b0);

    // Randomized traffic over a small register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      ID_rs      = 5'($urandom_range(0, 3));
      ID_rt      = 5'($urandom_range(0, 3));
      ID_UseRt   = 1'($urandom);
      ID_Branch  = ($urandom_range(0, 3) == 0);
      ID_JumpReg = !ID_Branch && ($urandom_range(0, 5) == 0);
      ID_Jump    = ID_JumpReg || (!ID_Branch && ($urandom_range(0, 7) == 0));
      ID_Taken   = 1'($urandom);
      ID_Valid   = ($urandom_range(0, 7) != 0);
      ID_PC31    = ($urandom_range(0, 9) == 0);
      IRQ        = ($urandom_range(0, 2) != 0);
      EX_RegWr   = 1'($urandom);
      EX_MemRd   = EX_RegWr && ($urandom_range(0, 2) == 0);
      EX_WrReg   = 5'($urandom_range(0, 3));
      MEM_RegWr  = 1'($urandom);
      MEM_MemRd  = MEM_RegWr && ($urandom_range(0, 2) == 0);
      MEM_WrReg  = 5'($urandom_range(0, 3));
      do_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
